serial_addsub_array: RTL
========================

# serial_addsub_array

Parametrised, multi-lane, bit-serial adder/subtractor. Each lane adds or subtracts two LSB-first serial operands of WORD_W bits, one bit per clock, and streams the sum out serially. Per-lane carry-out and signed-overflow flags are reported at word end. It sits between the serial operand shifters and the reservoir-state accumulators in the vector-matrix datapath, and supersedes the single-lane, add-only serial adder.

## Interface
Parameters:
- LANES, 4, number of independent serial lanes
- WORD_W, 16, bits per serial word (≥2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a word; bit 0 of the operands is presented in the same cycle
- sub  in  LANES  per-lane mode, sampled only with an accepted start: 0 = A+B, 1 = A−B
- a_bit  in  LANES  serial operand A, one bit per lane, LSB first
- b_bit  in  LANES  serial operand B, one bit per lane, LSB first
- s_bit  out  LANES  serial result, registered
- s_valid  out  1  s_bit carries a valid result bit
- busy  out  1  word in progress; start is ignored
- done  out  1  one-cycle pulse coincident with the MSB on s_bit
- cout  out  LANES  final carry-out; for sub, 1 = no borrow. Held until the next accepted start.
- ovf  out  LANES  signed two's-complement overflow of the finished word. Held until the next accepted start.

## Operation
- States: IDLE, RUN. Bit counter cnt has width $clog2(WORD_W).
- IDLE:
  - start=1 → accept. Latch sub into mode_q.
  - Each lane computes bit 0 with carry-in = sub[i]; B is inverted when sub[i]=1.
  - Register the sum bit and carry. cnt←1, go to RUN.
  - Clear cout and ovf.
- RUN:
  - Each cycle, process the next bit with the registered carry and B inverted per mode_q; cnt increments.
  - On the bit where cnt = WORD_W−1 (MSB):
    - cout[i] ← carry out of MSB.
    - ovf[i] ← carry-into-MSB XOR carry-out-of-MSB.
    - Assert done. Return to IDLE.
- start while busy=1: ignored; no effect on mode, carry or counter.
- A start in the cycle after the MSB is processed (busy=0) is accepted. Back-to-back words therefore have no gap.
- Lanes are fully independent; a mixed add/sub vector is legal.
- rst: has priority over start. Reset values:
  - State IDLE; cnt=0; carries=0.
  - s_bit=0, s_valid=0, busy=0, done=0, cout=0, ovf=0.
- Reset mid-word abandons the word. No done is issued and partial flags are discarded.

## Timing
- Cycle T: start is high. The edge ending T samples start, sub, a_bit[0] and b_bit[0].
- Operand bit k is sampled at the edge ending cycle T+k, for k = 0…WORD_W−1.
- Result bit k is visible on s_bit in cycle T+k+1, with s_valid=1. Latency is 1 cycle per bit.
- busy=1 during cycles T+1 … T+WORD_W−1.
- done=1 in cycle T+WORD_W only. In that cycle s_bit holds the MSB, and cout/ovf are valid.
- s_valid=1 during T+1 … T+WORD_W. It is 0 otherwise, unless a back-to-back word keeps it high continuously.
- While s_valid=0, s_bit holds 0.

## Structure
- Shared package serial_arith_pkg:
  - State enum {IDLE, RUN}.
  - Default LANE and WORD_W constants.
  - Counter-width function/localparam.
- Sub-module serial_fa_lane, one instance per lane via generate:
  - Inputs: a, b, inv_b, init_carry, load (first bit), en, rst.
  - Outputs: registered s, carry, and MSB carry-in tap for ovf.
- Top level holds the FSM, counter, mode_q, s_valid/busy/done and flag registers.

## Test plan
WORD_W=8, LANES=4 for all scenarios.
1. Add, lane 0: 100+27 → serial result 0x7F over T+1…T+8; done at T+8; cout=0, ovf=0.
2. Add, lane 1: 100+28 → 0x80, ovf=1, cout=0. Lane 2 in the same word: 0xFF+0x01 → 0x00, cout=1, ovf=0.
3. Mixed mode, sub=4'b0101:
   - Lane 0: 5−7 → 0xFE, cout=0, ovf=0.
   - Lane 2: 0x80−1 → 0x7F, ovf=1, cout=1.
   - Lanes 1/3 add correctly in the same word.
4. Back-to-back words:
   - start at T, second start at T+8 (busy=0), with flipped sub.
   - s_valid stays high T+1…T+16; done at T+8 and T+16.
   - Second word's results are correct; its sub is used, not the first word's.
5. start pulses at T+3 and T+7 during a word → ignored. Result, done timing and mode are unchanged.
6. rst at T+3 mid-word:
   - From T+4, all outputs are 0, with no done.
   - A new start at T+5 yields a correct word with done at T+13.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types, default sizes and bit-level helpers for the serial arithmetic lanes.
package serial_arith_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_LANES  = 4;
  localparam int DEF_WORD_W = 16;

  // Width of the bit counter; a 1-bit counter still works for 2-bit words.
  function automatic int cnt_width(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_fa_lane.sv
// One bit-serial full-adder lane: registered sum bit and carry, with combinational
// carry-in/carry-out taps so the top level can capture flags on the MSB.
module serial_fa_lane
  import serial_arith_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic inv_b,
  input  logic init_carry,
  input  logic load,
  input  logic en,
  output logic s,
  output logic cin_tap,
  output logic cout_tap
);

  logic carry_r;
  logic b_eff_s;
  logic cin_s;
  logic sum_s;
  logic cout_s;

  // First bit of a word takes its carry from the mode; later bits chain the stored carry.
  always_comb begin
    b_eff_s = b ^ inv_b;
    if (load) begin
      cin_s = init_carry;
    end else begin
      cin_s = carry_r;
    end
    sum_s  = fa_sum(a, b_eff_s, cin_s);
    cout_s = fa_carry(a, b_eff_s, cin_s);
  end

  assign cin_tap  = cin_s;
  assign cout_tap = cout_s;

  // Sum bit returns to 0 whenever the lane is not producing a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s       <= 1'b0;
      carry_r <= 1'b0;
    end else if (en) begin
      s       <= sum_s;
      carry_r <= cout_s;
    end else begin
      s       <= 1'b0;
      carry_r <= carry_r;
    end
  end

endmodule

// File: rtl/serial_addsub_array.sv
// Multi-lane bit-serial adder/subtractor: shared word FSM and counter, per-lane
// mode latched at start, carry-out and signed-overflow flags captured on the MSB.
module serial_addsub_array
  import serial_arith_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LANES-1:0] sub,
  input  logic [LANES-1:0] a_bit,
  input  logic [LANES-1:0] b_bit,
  output logic [LANES-1:0] s_bit,
  output logic             s_valid,
  output logic             busy,
  output logic             done,
  output logic [LANES-1:0] cout,
  output logic [LANES-1:0] ovf
);

  localparam int              CNT_W    = cnt_width(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  state_e           state_r;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [LANES-1:0] mode_r;
  logic [LANES-1:0] inv_b_s;
  logic [LANES-1:0] cin_tap_s;
  logic [LANES-1:0] cout_tap_s;
  logic             accept_s;
  logic             run_s;
  logic             last_s;
  logic             lane_en_s;

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state_r;
    accept_s  = 1'b0;
    run_s     = 1'b0;
    last_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s  = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        run_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          last_s    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The first bit uses the live sub input, since mode_r is not loaded until that edge.
  always_comb begin
    lane_en_s = accept_s | run_s;
    if (accept_s) begin
      inv_b_s = sub;
    end else begin
      inv_b_s = mode_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Bit counter and latched per-lane mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      mode_r <= '0;
    end else if (accept_s) begin
      cnt_r  <= CNT_W'(1);
      mode_r <= sub;
    end else if (run_s) begin
      cnt_r  <= last_s ? '0 : cnt_r + CNT_W'(1);
      mode_r <= mode_r;
    end else begin
      cnt_r  <= cnt_r;
      mode_r <= mode_r;
    end
  end

  // Status strobes line up with the lane sum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      s_valid <= accept_s | run_s;
      busy    <= accept_s | (run_s & ~last_s);
      done    <= last_s;
    end
  end

  // Flags clear on an accepted start and hold after the MSB until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cout <= '0;
      ovf  <= '0;
    end else if (accept_s) begin
      cout <= '0;
      ovf  <= '0;
    end else if (last_s) begin
      cout <= cout_tap_s;
      ovf  <= cin_tap_s ^ cout_tap_s;
    end else begin
      cout <= cout;
      ovf  <= ovf;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    serial_fa_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .a          (a_bit[i]),
      .b          (b_bit[i]),
      .inv_b      (inv_b_s[i]),
      .init_carry (sub[i]),
      .load       (accept_s),
      .en         (lane_en_s),
      .s          (s_bit[i]),
      .cin_tap    (cin_tap_s[i]),
      .cout_tap   (cout_tap_s[i])
    );
  end

endmodule
